// File: rtl/mu_local_mem_arbiter_pkg.sv
// Shared types for the local-memory arbiter: requester ids and the read tag
// that routes each read response back to whoever issued it.
package mu_local_mem_arbiter_pkg;

    localparam int unsigned MEM_BURST_W   = 3;
    localparam int unsigned MEM_MAX_BURST = 4;

    typedef enum logic {
        REQ_DMA = 1'b0,
        REQ_MU  = 1'b1
    } mem_req_id_e;

    typedef struct packed {
        mem_req_id_e            id;
        logic [MEM_BURST_W-1:0] beats;
    } rd_tag_t;

endpackage

// File: rtl/mu_rd_tag_fifo.sv
// Synchronous FIFO of read tags. Push while full is accepted only if a pop
// frees the head slot in the same cycle.
module mu_rd_tag_fifo
    import mu_local_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  rd_tag_t push_data_i,
    input  logic    pop_i,
    output rd_tag_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    rd_tag_t          mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/mu_local_mem_arbiter.sv
// Round-robin arbiter sharing one local-memory Avalon-MM bank between the host
// DMA path (requester 0) and the matmul unit (requester 1).
module mu_local_mem_arbiter
    import mu_local_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned BURST_W      = MEM_BURST_W,
    parameter int unsigned TAG_DEPTH    = 8,
    parameter int unsigned MAX_RD_BEATS = 32
) (
    input  logic                           primary_clk,
    input  logic                           reset_n,
    input  logic [1:0]                     req_read,
    input  logic [1:0]                     req_write,
    input  logic [1:0][ADDR_W-1:0]         req_address,
    input  logic [1:0][BURST_W-1:0]        req_burstcount,
    input  logic [1:0][DATA_W-1:0]         req_writedata,
    input  logic [1:0][DATA_W/8-1:0]       req_byteenable,
    output logic [1:0]                     req_waitrequest,
    output logic [DATA_W-1:0]              req_readdata,
    output logic [1:0]                     req_readdatavalid,
    input  logic                           m_waitrequest,
    input  logic [DATA_W-1:0]              m_readdata,
    input  logic                           m_readdatavalid,
    output logic                           m_read,
    output logic                           m_write,
    output logic [ADDR_W-1:0]              m_address,
    output logic [BURST_W-1:0]             m_burstcount,
    output logic [DATA_W-1:0]              m_writedata,
    output logic [DATA_W/8-1:0]            m_byteenable,
    output logic                           err_rsp
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_WBURST = 2'd2;

    // One spare bit so rd_beats + bc never wraps before the limit compare.
    localparam int unsigned CNT_W = $clog2(MAX_RD_BEATS + 1) + 1;

    logic [1:0]               state_q, state_d;
    logic                     gnt_q, gnt_d;
    logic                     rr_q, rr_d;
    logic [BURST_W-1:0]       beats_left_q, beats_left_d;
    logic [CNT_W-1:0]         rd_beats_q, rd_beats_d;
    logic [MEM_BURST_W-1:0]   head_cnt_q, head_cnt_d;
    logic [DATA_W-1:0]        rdata_q;
    logic [1:0]               rdv_q, rdv_d;
    logic                     err_q;

    logic [1:0][BURST_W-1:0]  bc;
    logic [1:0]               elig;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     beat_ok;
    logic                     head_last;
    logic                     tag_full;
    logic                     tag_empty;
    rd_tag_t                  tag_head;
    rd_tag_t                  tag_push;

    always_comb begin
        bc   = '0;
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            bc[i]   = (req_burstcount[i] == '0) ? BURST_W'(1) : req_burstcount[i];
            elig[i] = req_write[i] ||
                      (req_read[i] && !tag_full &&
                       ((rd_beats_q + CNT_W'(bc[i])) <= CNT_W'(MAX_RD_BEATS)));
        end
    end

    always_comb begin
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_address       = '0;
        m_burstcount    = '0;
        m_writedata     = '0;
        m_byteenable    = '0;
        req_waitrequest = 2'b11;
        if (state_q != ST_IDLE) begin
            m_read                 = (state_q == ST_CMD) && req_read[gnt_q];
            m_write                = req_write[gnt_q];
            m_address              = req_address[gnt_q];
            m_burstcount           = req_burstcount[gnt_q];
            m_writedata            = req_writedata[gnt_q];
            m_byteenable           = req_byteenable[gnt_q];
            req_waitrequest[gnt_q] = m_waitrequest;
        end
    end

    assign accept = (m_read || m_write) && !m_waitrequest;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        beats_left_d = beats_left_q;
        push         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    gnt_d   = elig[rr_q] ? rr_q : ~rr_q;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                // A requester dropping its command mid-grant releases the bus
                // without earning the round-robin turn.
                if (!req_read[gnt_q] && !req_write[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (m_read) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                        rr_d    = ~gnt_q;
                    end else if (bc[gnt_q] == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                        rr_d    = ~gnt_q;
                    end else begin
                        beats_left_d = bc[gnt_q] - BURST_W'(1);
                        state_d      = ST_WBURST;
                    end
                end
            end
            ST_WBURST: begin
                if (accept) begin
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                        rr_d    = ~gnt_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tag_push.id    = mem_req_id_e'(gnt_q);
    assign tag_push.beats = MEM_BURST_W'(bc[gnt_q]);

    assign beat_ok   = m_readdatavalid && !tag_empty;
    assign head_last = (head_cnt_q + MEM_BURST_W'(1)) == tag_head.beats;
    assign pop       = beat_ok && head_last;

    always_comb begin
        rd_beats_d = rd_beats_q;
        if (push)    rd_beats_d = rd_beats_d + CNT_W'(bc[gnt_q]);
        if (beat_ok) rd_beats_d = rd_beats_d - CNT_W'(1);

        head_cnt_d = head_cnt_q;
        if (beat_ok) head_cnt_d = head_last ? '0 : head_cnt_q + MEM_BURST_W'(1);

        rdv_d = 2'b00;
        if (beat_ok) rdv_d = (tag_head.id == REQ_MU) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge primary_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            rr_q         <= 1'b0;
            beats_left_q <= '0;
            rd_beats_q   <= '0;
            head_cnt_q   <= '0;
            rdata_q      <= '0;
            rdv_q        <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            beats_left_q <= beats_left_d;
            rd_beats_q   <= rd_beats_d;
            head_cnt_q   <= head_cnt_d;
            rdata_q      <= m_readdata;
            rdv_q        <= rdv_d;
            if (m_readdatavalid && tag_empty) err_q <= 1'b1;
        end
    end

    assign req_readdata      = rdata_q;
    assign req_readdatavalid = rdv_q;
    assign err_rsp           = err_q;

    mu_rd_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_rd_tag_fifo (
        .clk_i       (primary_clk),
        .rst_ni      (reset_n),
        .push_i      (push),
        .push_data_i (tag_push),
        .pop_i       (pop),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    a_burst_in_range: assert property (@(posedge primary_clk) disable iff (!reset_n)
        (state_q != ST_IDLE) |-> (m_burstcount <= BURST_W'(MEM_MAX_BURST)));

endmodule

// File: tb/tb_mu_local_mem_arbiter.sv
// Directed bench for mu_local_mem_arbiter: a per-cycle vector table for
// contention, response routing and write-burst locking, then hand sequences.
module tb_mu_local_mem_arbiter;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 3;
    localparam logic [AW-1:0] ADDR_DMA = 27'h100;
    localparam logic [AW-1:0] ADDR_MU  = 27'h200;

    logic                   primary_clk = 1'b0;
    logic                   reset_n;
    logic [1:0]             req_read;
    logic [1:0]             req_write;
    logic [1:0][AW-1:0]     req_address;
    logic [1:0][BW-1:0]     req_burstcount;
    logic [1:0][DW-1:0]     req_writedata;
    logic [1:0][DW/8-1:0]   req_byteenable;
    logic [1:0]             req_waitrequest;
    logic [DW-1:0]          req_readdata;
    logic [1:0]             req_readdatavalid;
    logic                   m_waitrequest;
    logic [DW-1:0]          m_readdata;
    logic                   m_readdatavalid;
    logic                   m_read;
    logic                   m_write;
    logic [AW-1:0]          m_address;
    logic [BW-1:0]          m_burstcount;
    logic [DW-1:0]          m_writedata;
    logic [DW/8-1:0]        m_byteenable;
    logic                   err_rsp;

    int checks   = 0;
    int failures = 0;

    always #5 primary_clk = ~primary_clk;

    mu_local_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .BURST_W      (BW),
        .TAG_DEPTH    (8),
        .MAX_RD_BEATS (32)
    ) dut (
        .primary_clk       (primary_clk),
        .reset_n           (reset_n),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_burstcount    (req_burstcount),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .m_waitrequest     (m_waitrequest),
        .m_readdata        (m_readdata),
        .m_readdatavalid   (m_readdatavalid),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_address         (m_address),
        .m_burstcount      (m_burstcount),
        .m_writedata       (m_writedata),
        .m_byteenable      (m_byteenable),
        .err_rsp           (err_rsp)
    );

    // ex_gnt: 0 = no grant (m_* zero), 1 = DMA drives m_*, 2 = MU drives m_*.
    typedef struct {
        logic [1:0]    rd;
        logic [1:0]    wr;
        logic [BW-1:0] bc0;
        logic [BW-1:0] bc1;
        logic          mw;
        logic          rdv;
        logic          ex_rd;
        logic          ex_wr;
        logic [1:0]    ex_wait;
        logic [1:0]    ex_rdv;
        int            ex_gnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] rd, wr, input logic [BW-1:0] bc0, bc1,
                                input logic mw, rdv, ex_rd, ex_wr,
                                input logic [1:0] ex_wait, ex_rdv, input int ex_gnt);
        vec_t v;
        v.rd = rd; v.wr = wr; v.bc0 = bc0; v.bc1 = bc1; v.mw = mw; v.rdv = rdv;
        v.ex_rd = ex_rd; v.ex_wr = ex_wr; v.ex_wait = ex_wait; v.ex_rdv = ex_rdv;
        v.ex_gnt = ex_gnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rd, wr, input logic [BW-1:0] bc0, bc1,
                         input logic mw, rdv);
        req_read          = rd;
        req_write         = wr;
        req_burstcount[0] = bc0;
        req_burstcount[1] = bc1;
        m_waitrequest     = mw;
        m_readdatavalid   = rdv;
    endtask

    task automatic next_cycle();
        @(posedge primary_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge primary_clk);
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        reset_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        logic [AW-1:0] ex_addr;
        logic [BW-1:0] ex_bc;
        logic [DW-1:0] prev_rdata;
        int acc;
        int wacc;
        int racc;
        int stall_bad;
        int act_cnt;

        // Contention: 4 alternating reads each, then 8 in-order beats.
        tbl.push_back(mk(2'b11, 2'b00, 3'd1, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(2'b11, 2'b00, 3'd1, 3'd1, 0, 0, 1, 0, 2'b10, 2'b00, 1));
            tbl.push_back(mk(2'b11, 2'b00, 3'd1, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
            tbl.push_back(mk(2'b11, 2'b00, 3'd1, 3'd1, 0, 0, 1, 0, 2'b01, 2'b00, 2));
            if (k < 3) tbl.push_back(mk(2'b11, 2'b00, 3'd1, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
        end
        for (int j = 0; j < 8; j++) begin
            tbl.push_back(mk(2'b00, 2'b00, 3'd1, 3'd1, 0, 1, 0, 0, 2'b11,
                             (j == 0) ? 2'b00 : (((j - 1) % 2 == 0) ? 2'b01 : 2'b10), 0));
        end
        tbl.push_back(mk(2'b00, 2'b00, 3'd1, 3'd1, 0, 0, 0, 0, 2'b11, 2'b10, 0));
        tbl.push_back(mk(2'b00, 2'b00, 3'd1, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
        // Write burst lock: DMA bc=4 with a stall on beat 2, MU waits its turn.
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 1, 0, 0, 1, 2'b11, 2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));
        tbl.push_back(mk(2'b00, 2'b11, 3'd4, 3'd1, 0, 0, 0, 1, 2'b01, 2'b00, 2));
        tbl.push_back(mk(2'b00, 2'b00, 3'd4, 3'd1, 0, 0, 0, 0, 2'b11, 2'b00, 0));

        req_address[0]    = ADDR_DMA;
        req_address[1]    = ADDR_MU;
        req_writedata[0]  = 32'hD0D0_0000;
        req_writedata[1]  = 32'h3030_0000;
        req_byteenable[0] = '1;
        req_byteenable[1] = '1;
        m_readdata        = '0;

        // Reset holds the bus idle even with both requesters reading.
        reset_n = 1'b0;
        drive(2'b11, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        #12;
        chk("reset m_read", 64'(m_read), 64'h0);
        chk("reset m_write", 64'(m_write), 64'h0);
        chk("reset waitrequest", 64'(req_waitrequest), 64'h3);
        chk("reset readdatavalid", 64'(req_readdatavalid), 64'h0);
        chk("reset readdata", 64'(req_readdata), 64'h0);
        chk("reset m_address", 64'(m_address), 64'h0);
        chk("reset err_rsp", 64'(err_rsp), 64'h0);
        drive(2'b00, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        reset_n = 1'b1;
        next_cycle();

        prev_rdata = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].bc0, tbl[i].bc1, tbl[i].mw, tbl[i].rdv);
            m_readdata = 32'hA500_0000 + 32'(i);
            @(negedge primary_clk);
            ex_addr = (tbl[i].ex_gnt == 1) ? ADDR_DMA : (tbl[i].ex_gnt == 2) ? ADDR_MU : '0;
            ex_bc   = (tbl[i].ex_gnt == 1) ? tbl[i].bc0 : (tbl[i].ex_gnt == 2) ? tbl[i].bc1 : '0;
            chk($sformatf("row%0d m_read", i), 64'(m_read), 64'(tbl[i].ex_rd));
            chk($sformatf("row%0d m_write", i), 64'(m_write), 64'(tbl[i].ex_wr));
            chk($sformatf("row%0d waitrequest", i), 64'(req_waitrequest), 64'(tbl[i].ex_wait));
            chk($sformatf("row%0d readdatavalid", i), 64'(req_readdatavalid),
                64'(tbl[i].ex_rdv));
            chk($sformatf("row%0d m_address", i), 64'(m_address), 64'(ex_addr));
            chk($sformatf("row%0d m_burstcount", i), 64'(m_burstcount), 64'(ex_bc));
            if (tbl[i].ex_rdv != 2'b00)
                chk($sformatf("row%0d readdata", i), 64'(req_readdata), 64'(prev_rdata));
            prev_rdata = m_readdata;
            next_cycle();
        end

        // Outstanding limit: MU reads bc=4 with no responses, 8 tags then stall.
        apply_reset();
        drive(2'b10, 2'b00, 3'd1, 3'd4, 1'b0, 1'b0);
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge primary_clk);
            if (m_read && !m_waitrequest && m_address == ADDR_MU) acc++;
            next_cycle();
        end
        chk("limit accepted reads", 64'(acc), 64'd8);

        // DMA writes still get through while MU reads are stalled.
        drive(2'b10, 2'b01, 3'd1, 3'd4, 1'b0, 1'b0);
        wacc = 0; racc = 0; stall_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge primary_clk);
            if (m_write && !m_waitrequest && m_address == ADDR_DMA) wacc++;
            if (m_read) racc++;
            if (req_waitrequest[1] !== 1'b1) stall_bad++;
            next_cycle();
        end
        chk("stall dma writes", 64'(wacc), 64'd4);
        chk("stall mu reads", 64'(racc), 64'd0);
        chk("stall mu waitrequest", 64'(stall_bad), 64'd0);

        // Return one 4-beat response: routed to MU, then the 9th read goes out.
        drive(2'b10, 2'b00, 3'd1, 3'd4, 1'b0, 1'b0);
        racc = 0;
        for (int c = 0; c < 10; c++) begin
            m_readdatavalid = (c < 4);
            @(negedge primary_clk);
            chk($sformatf("limit rdv c%0d", c), 64'(req_readdatavalid),
                (c >= 1 && c <= 4) ? 64'h2 : 64'h0);
            if (m_read && !m_waitrequest) racc++;
            next_cycle();
        end
        chk("limit resumed reads", 64'(racc), 64'd1);

        // Reset in the middle of a write burst kills the burst immediately.
        apply_reset();
        drive(2'b00, 2'b01, 3'd4, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        chk("midburst idle m_write", 64'(m_write), 64'h0);
        next_cycle();
        @(negedge primary_clk);
        chk("midburst beat1 m_write", 64'(m_write), 64'h1);
        next_cycle();
        @(negedge primary_clk);
        chk("midburst beat2 m_write", 64'(m_write), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("midburst reset m_write", 64'(m_write), 64'h0);
        chk("midburst reset waitrequest", 64'(req_waitrequest), 64'h3);
        drive(2'b00, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        reset_n = 1'b1;
        act_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge primary_clk);
            if (m_write || m_read) act_cnt++;
        end
        chk("post reset m activity", 64'(act_cnt), 64'd0);

        // Same-cycle push/pop, then a spurious beat with the FIFO empty.
        apply_reset();
        drive(2'b01, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        chk("pp c0 m_read", 64'(m_read), 64'h0);
        next_cycle();
        @(negedge primary_clk);
        chk("pp c1 m_read", 64'(m_read), 64'h1);
        chk("pp c1 m_address", 64'(m_address), 64'(ADDR_DMA));
        next_cycle();
        drive(2'b10, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        chk("pp c2 m_read", 64'(m_read), 64'h0);
        next_cycle();
        drive(2'b10, 2'b00, 3'd1, 3'd1, 1'b0, 1'b1);
        m_readdata = 32'h1111_0001;
        @(negedge primary_clk);
        chk("pp c3 m_read", 64'(m_read), 64'h1);
        chk("pp c3 m_address", 64'(m_address), 64'(ADDR_MU));
        next_cycle();
        drive(2'b00, 2'b00, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge primary_clk);
        chk("pp c4 rdv", 64'(req_readdatavalid), 64'h1);
        chk("pp c4 readdata", 64'(req_readdata), 64'h1111_0001);
        next_cycle();
        m_readdatavalid = 1'b1;
        m_readdata      = 32'h2222_0002;
        @(negedge primary_clk);
        chk("pp c5 rdv", 64'(req_readdatavalid), 64'h0);
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge primary_clk);
        chk("pp c6 rdv", 64'(req_readdatavalid), 64'h2);
        chk("pp c6 readdata", 64'(req_readdata), 64'h2222_0002);
        chk("pp c6 err_rsp", 64'(err_rsp), 64'h0);
        next_cycle();
        m_readdatavalid = 1'b1;
        m_readdata      = 32'h3333_0003;
        @(negedge primary_clk);
        chk("spurious c7 err_rsp", 64'(err_rsp), 64'h0);
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge primary_clk);
        chk("spurious c8 rdv", 64'(req_readdatavalid), 64'h0);
        chk("spurious c8 err_rsp", 64'(err_rsp), 64'h1);
        next_cycle();
        next_cycle();
        @(negedge primary_clk);
        chk("spurious sticky err_rsp", 64'(err_rsp), 64'h1);
        apply_reset();
        @(negedge primary_clk);
        chk("reset clears err_rsp", 64'(err_rsp), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
